// File: rtl/feature_evaluator.sv
// ============================================================================
// feature_evaluator : point-to-feature accumulation, weak-classifier and stage
//                     verdict for the cascade evaluator.
// Optional: FEATURE_EVALUATOR_STAGE_SAT_EN saturates the 32-bit stage sum.
// Revision: 1.0
// ============================================================================
`default_nettype none

module feature_evaluator #(
  parameter int ADDR_WIDTH = 30,
  parameter int II_WIDTH   = 32,
  parameter int FEAT_WIDTH = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_ii_i,
  input  logic                  val_ii_i,
  input  logic [3:0]            weight_i,
  input  logic [3:0]            num_point_i,
  input  logic [31:0]           thresholds_i,
  input  logic [1:0]            thresholds_type_i,
  input  logic                  thresholds_val_i,
  input  logic [31:0]           stage_threshold_i,
  input  logic                  stage_threshold_val_i,
  output logic [ADDR_WIDTH-1:0] ii_addr_o,
  output logic                  ii_rd_o,
  input  logic [II_WIDTH-1:0]   ii_data_i,
  output logic                  stage_done_o,
  output logic                  stage_pass_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    STAGE   = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic                         s1_vld_q, s1_vld_d;
  logic                         s1_neg_q, s1_neg_d;
  logic [3:0]                   s1_wgt_q, s1_wgt_d;
  logic                         s2_vld_q, s2_vld_d;
  logic signed [FEAT_WIDTH-1:0] prod_q, prod_d;
  logic signed [FEAT_WIDTH-1:0] feat_acc_q, feat_acc_d;
  logic [1:0]                   pend_q, pend_d;
  logic [31:0]                  thr_q, thr_d;
  logic [31:0]                  lval_q, lval_d;
  logic [31:0]                  rval_q, rval_d;
  logic                         resolve_q, resolve_d;
  logic                         stage_req_q, stage_req_d;
  logic [31:0]                  stage_thr_q, stage_thr_d;
  logic [31:0]                  stage_sum_q, stage_sum_d;

  logic                         w_accept;
  logic                         w_type2;
  logic                         w_resolve;
  logic                         w_fire;
  logic                         w_take_left;
  logic                         w_pass;
  logic signed [FEAT_WIDTH-1:0] w_data_ext;
  logic signed [FEAT_WIDTH-1:0] w_term;
  logic signed [FEAT_WIDTH-1:0] w_wgt_ext;
  logic signed [FEAT_WIDTH-1:0] w_prod;
  logic signed [FEAT_WIDTH-1:0] w_thr_ext;
  logic [31:0]                  w_addend;
  logic [31:0]                  w_sum_next;

  // Corners 4..15 are not real points: no read, no pend increment.
  assign w_accept  = val_ii_i & ~|num_point_i[3:2];
  assign ii_rd_o   = w_accept & ~rst_i;
  assign ii_addr_o = (w_accept & ~rst_i) ? addr_ii_i : '0;

  assign w_data_ext = {{(FEAT_WIDTH-II_WIDTH){1'b0}}, ii_data_i};
  assign w_term     = s1_neg_q ? -w_data_ext : w_data_ext;
  assign w_wgt_ext  = {{(FEAT_WIDTH-4){s1_wgt_q[3]}}, s1_wgt_q};
  assign w_prod     = w_term * w_wgt_ext;

  assign w_thr_ext   = {{(FEAT_WIDTH-32){thr_q[31]}}, thr_q};
  assign w_take_left = feat_acc_q < w_thr_ext;
  assign w_addend    = w_take_left ? lval_q : rval_q;

  assign w_type2   = thresholds_val_i & (thresholds_type_i == 2'd2);
  assign w_resolve = resolve_q & (pend_q == 2'd0);
  assign w_fire    = (state_q == STAGE) & ~resolve_q & (pend_q == 2'd0);
  assign w_pass    = $signed(stage_sum_q) >= $signed(stage_thr_q);

`ifdef FEATURE_EVALUATOR_STAGE_SAT_EN
  logic [32:0] w_sum_wide;
  assign w_sum_wide = {stage_sum_q[31], stage_sum_q} + {w_addend[31], w_addend};
  // Sign bits disagree only on signed overflow; clamp toward the overflow side.
  assign w_sum_next = (w_sum_wide[32] != w_sum_wide[31]) ?
                      (w_sum_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) :
                      w_sum_wide[31:0];
`else
  assign w_sum_next = stage_sum_q + w_addend;
`endif

  always_comb begin
    state_d     = state_q;
    s1_vld_d    = w_accept;
    s1_neg_d    = ^num_point_i[1:0];
    s1_wgt_d    = weight_i;
    s2_vld_d    = s1_vld_q;
    prod_d      = w_prod;
    feat_acc_d  = feat_acc_q;
    pend_d      = pend_q + {1'b0, w_accept} - {1'b0, s2_vld_q};
    thr_d       = thr_q;
    lval_d      = lval_q;
    rval_d      = rval_q;
    resolve_d   = resolve_q;
    stage_req_d = stage_req_q;
    stage_thr_d = stage_thr_q;
    stage_sum_d = stage_sum_q;

    if (thresholds_val_i) begin
      case (thresholds_type_i)
        2'd0:    thr_d  = thresholds_i;
        2'd1:    lval_d = thresholds_i;
        2'd2:    rval_d = thresholds_i;
        default: ;
      endcase
    end
    if (stage_threshold_val_i) stage_thr_d = stage_threshold_i;

    // Resolution needs pend == 0, so it never coincides with an accumulate.
    if (w_resolve) begin
      feat_acc_d  = '0;
      resolve_d   = 1'b0;
      stage_sum_d = w_sum_next;
    end else if (s2_vld_q) begin
      feat_acc_d = feat_acc_q + prod_q;
    end
    if (w_type2) resolve_d = 1'b1;
    if (w_fire) stage_sum_d = '0;

    case (state_q)
      ACC: begin
        if (w_type2) begin
          state_d = RESOLVE;
          if (stage_threshold_val_i) stage_req_d = 1'b1;
        end else if (stage_threshold_val_i) begin
          state_d = STAGE;
        end
      end
      RESOLVE: begin
        if (stage_threshold_val_i) stage_req_d = 1'b1;
        if (w_resolve) begin
          state_d     = (stage_req_q | stage_threshold_val_i) ? STAGE : ACC;
          stage_req_d = 1'b0;
        end
      end
      STAGE: begin
        if (w_fire) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ACC;
      s1_vld_q    <= 1'b0;
      s1_neg_q    <= 1'b0;
      s1_wgt_q    <= '0;
      s2_vld_q    <= 1'b0;
      prod_q      <= '0;
      feat_acc_q  <= '0;
      pend_q      <= '0;
      thr_q       <= '0;
      lval_q      <= '0;
      rval_q      <= '0;
      resolve_q   <= 1'b0;
      stage_req_q <= 1'b0;
      stage_thr_q <= '0;
      stage_sum_q <= '0;
    end else begin
      state_q     <= state_d;
      s1_vld_q    <= s1_vld_d;
      s1_neg_q    <= s1_neg_d;
      s1_wgt_q    <= s1_wgt_d;
      s2_vld_q    <= s2_vld_d;
      prod_q      <= prod_d;
      feat_acc_q  <= feat_acc_d;
      pend_q      <= pend_d;
      thr_q       <= thr_d;
      lval_q      <= lval_d;
      rval_q      <= rval_d;
      resolve_q   <= resolve_d;
      stage_req_q <= stage_req_d;
      stage_thr_q <= stage_thr_d;
      stage_sum_q <= stage_sum_d;
    end
  end

  assign stage_done_o = w_fire & ~rst_i;
  assign stage_pass_o = w_fire & ~rst_i & w_pass;
  assign busy_o       = ~rst_i & ((state_q != ACC) | (pend_q != 2'd0));

endmodule

`default_nettype wire

// File: tb/tb_feature_evaluator.sv
// ============================================================================
// tb_feature_evaluator : table-driven vectors plus timing, saturation and
//                        reset sequences for feature_evaluator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_feature_evaluator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [29:0] addr_ii_i;
  logic        val_ii_i;
  logic [3:0]  weight_i;
  logic [3:0]  num_point_i;
  logic [31:0] thresholds_i;
  logic [1:0]  thresholds_type_i;
  logic        thresholds_val_i;
  logic [31:0] stage_threshold_i;
  logic        stage_threshold_val_i;
  logic [29:0] ii_addr_o;
  logic        ii_rd_o;
  logic [31:0] ii_data_i;
  logic        stage_done_o;
  logic        stage_pass_o;
  logic        busy_o;

  feature_evaluator #(.ADDR_WIDTH(30), .II_WIDTH(32), .FEAT_WIDTH(40)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .addr_ii_i(addr_ii_i), .val_ii_i(val_ii_i), .weight_i(weight_i),
    .num_point_i(num_point_i),
    .thresholds_i(thresholds_i), .thresholds_type_i(thresholds_type_i),
    .thresholds_val_i(thresholds_val_i),
    .stage_threshold_i(stage_threshold_i),
    .stage_threshold_val_i(stage_threshold_val_i),
    .ii_addr_o(ii_addr_o), .ii_rd_o(ii_rd_o), .ii_data_i(ii_data_i),
    .stage_done_o(stage_done_o), .stage_pass_o(stage_pass_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Integral-image RAM with one-cycle read latency.
  logic [31:0] mem [0:7];
  always @(posedge clk_i) begin
    if (ii_rd_o) ii_data_i <= mem[ii_addr_o[2:0]];
    else         ii_data_i <= 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic [7:0][31:0] d;
    logic [3:0]       w0;
    logic [3:0]       w1;
    logic [31:0]      thr;
    logic [31:0]      lval;
    logic [31:0]      rval;
    logic [31:0]      sthr;
    logic             exp_pass;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q [$];
  logic prev_done = 1'b0;

  always @(negedge clk_i) begin
    if (stage_done_o) begin
      if (prev_done) begin
        n_cmp++; n_err++;
        $display("FAIL done_back_to_back: got two consecutive pulses, required one");
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got stage_done_o=1 with no verdict expected");
      end else begin
        automatic logic e = exp_q.pop_front();
        if (stage_pass_o !== e) begin
          n_err++;
          $display("FAIL stage_pass: got %0b required %0b", stage_pass_o, e);
        end
      end
    end
    prev_done = stage_done_o;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic send_point(int a, int np, logic [3:0] w);
    val_ii_i = 1'b1; addr_ii_i = 30'(a); num_point_i = 4'(np); weight_i = w;
    tick();
    val_ii_i = 1'b0;
  endtask

  task automatic send_thr(logic [1:0] t, logic [31:0] v);
    thresholds_val_i = 1'b1; thresholds_type_i = t; thresholds_i = v;
    tick();
    thresholds_val_i = 1'b0;
  endtask

  task automatic send_stage(logic [31:0] v, logic e);
    stage_threshold_val_i = 1'b1; stage_threshold_i = v;
    exp_q.push_back(e);
    tick();
    stage_threshold_val_i = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy_o) && k < 60) begin
      @(negedge clk_i); k++;
    end
    check({name, "_drain_timeout"}, {31'd0, busy_o | (exp_q.size() != 0)}, 32'd0);
    tick();
  endtask

  task automatic run_feature(vec_t v, bit do_stage, string name);
    for (int i = 0; i < 8; i++) mem[i] = v.d[i];
    for (int i = 0; i < 8; i++) send_point(i, i % 4, (i < 4) ? v.w0 : v.w1);
    send_thr(2'd0, v.thr);
    send_thr(2'd1, v.lval);
    send_thr(2'd2, v.rval);
    if (do_stage) send_stage(v.sthr, v.exp_pass);
    wait_drain(name);
  endtask

  function automatic vec_t mk(logic [31:0] a0, logic [31:0] a1, logic [31:0] a2,
                              logic [31:0] a3, logic [31:0] b0, logic [31:0] b1,
                              logic [31:0] b2, logic [31:0] b3, logic [3:0] w0,
                              logic [3:0] w1, logic [31:0] thr, logic [31:0] lv,
                              logic [31:0] rv, logic [31:0] st, logic ep);
    vec_t v;
    v.d[0] = a0; v.d[1] = a1; v.d[2] = a2; v.d[3] = a3;
    v.d[4] = b0; v.d[5] = b1; v.d[6] = b2; v.d[7] = b3;
    v.w0 = w0; v.w1 = w1; v.thr = thr; v.lval = lv; v.rval = rv;
    v.sthr = st; v.exp_pass = ep;
    return v;
  endfunction

  vec_t vecs [8];
  vec_t sat_v;

  initial begin
    rst_i = 1'b1; val_ii_i = 1'b0; addr_ii_i = '0; weight_i = '0; num_point_i = '0;
    thresholds_i = '0; thresholds_type_i = '0; thresholds_val_i = 1'b0;
    stage_threshold_i = '0; stage_threshold_val_i = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // feat = 18 for the reference feature (rect sums 4 and 11, weights -1 and 2)
    vecs[0] = mk(10, 3, 4, 1, 20, 5, 6, 2, 4'hF, 4'h2, 5,   7, 32'hFFFFFFFD, 32'hFFFFFFFD, 1'b1);
    vecs[1] = mk(10, 3, 4, 1, 20, 5, 6, 2, 4'hF, 4'h2, 100, 7, 32'hFFFFFFFD, 8,            1'b0);
    vecs[2] = mk(10, 3, 4, 1, 20, 5, 6, 2, 4'hF, 4'h2, 18,  7, 32'hFFFFFFFD, 32'hFFFFFFFC, 1'b1);
    vecs[3] = mk(10, 3, 4, 1, 20, 5, 6, 2, 4'hF, 4'h2, 19,  7, 32'hFFFFFFFD, 7,            1'b1);
    // feat = 300 - 70 = 230 vs thr -1000 -> rval 1000 < 1001
    vecs[4] = mk(100, 0, 0, 0, 50, 10, 10, 5, 4'h3, 4'hE, 32'hFFFFFC18, 0, 1000, 1001, 1'b0);
    // feat = -2 * -8 = 16 < 17 -> lval -5 >= -5
    vecs[5] = mk(0, 1, 1, 0, 0, 0, 0, 0, 4'h8, 4'h7, 17, 32'hFFFFFFFB, 3, 32'hFFFFFFFB, 1'b1);
    // feat = 7 * (2^32-1), far above any 32-bit threshold -> rval
    vecs[6] = mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 4'h7, 4'h0, 32'h7FFFFFFF,
                 32'hFFFFFFFF, 1, 1, 1'b1);
    // feat = -5, equal to thr -> rval 2 >= 0
    vecs[7] = mk(0, 5, 0, 0, 0, 0, 0, 0, 4'h1, 4'h0, 32'hFFFFFFFB, 32'hFFFFFFFE, 2, 0, 1'b1);

    repeat (3) tick();
    @(negedge clk_i);
    check("rst_done", {31'd0, stage_done_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    rst_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("idle_addr", {2'd0, ii_addr_o}, 0);
    check("idle_rd", {31'd0, ii_rd_o}, 0);
    check("idle_pass", {31'd0, stage_pass_o}, 0);
    check("idle_busy", {31'd0, busy_o}, 0);
    tick();

    for (int i = 0; i < 8; i++) run_feature(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Right value and stage threshold together, one cycle after the last point.
    for (int i = 0; i < 8; i++) mem[i] = vecs[0].d[i];
    send_thr(2'd0, 5);
    send_thr(2'd1, 7);
    for (int i = 0; i < 7; i++) send_point(i, i % 4, (i < 4) ? 4'hF : 4'h2);
    val_ii_i = 1'b1; addr_ii_i = 30'd7; num_point_i = 4'd3; weight_i = 4'h2;
    @(negedge clk_i);
    check("seqA_rd_last", {31'd0, ii_rd_o}, 1);
    check("seqA_busy_t0", {31'd0, busy_o}, 1);
    tick();
    val_ii_i = 1'b0;
    thresholds_val_i = 1'b1; thresholds_type_i = 2'd2; thresholds_i = 32'hFFFFFFFD;
    stage_threshold_val_i = 1'b1; stage_threshold_i = 32'hFFFFFFFE;
    exp_q.push_back(1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      check($sformatf("seqA_busy_t%0d", k), {31'd0, busy_o}, (k <= 4) ? 1 : 0);
      check($sformatf("seqA_done_t%0d", k), {31'd0, stage_done_o}, (k == 4) ? 1 : 0);
      tick();
      thresholds_val_i = 1'b0; stage_threshold_val_i = 1'b0;
    end
    wait_drain("seqA");

    // Two large right values accumulate into the stage sum.
    sat_v = mk(10, 3, 4, 1, 20, 5, 6, 2, 4'hF, 4'h2, 32'hFFFFFC18, 0, 32'h7FFFFFF0,
               32'h7FFFFFFF,
`ifdef FEATURE_EVALUATOR_STAGE_SAT_EN
               1'b1);
`else
               1'b0);
`endif
    run_feature(sat_v, 1'b0, "sat1");
    run_feature(sat_v, 1'b1, "sat2");

    // Corner index above 3 is not a point.
    val_ii_i = 1'b1; addr_ii_i = 30'd3; num_point_i = 4'd5; weight_i = 4'h1;
    @(negedge clk_i);
    check("np5_rd", {31'd0, ii_rd_o}, 0);
    tick();
    val_ii_i = 1'b0;
    @(negedge clk_i);
    check("np5_busy", {31'd0, busy_o}, 0);
    tick();

    // Reset with two negated points in flight; they must not reach feat_acc.
    mem[0] = 100; mem[1] = 100;
    send_point(0, 1, 4'h1);
    send_point(1, 2, 4'h1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_busy", {31'd0, busy_o}, 0);
    check("rst_mid_rd", {31'd0, ii_rd_o}, 0);
    check("rst_mid_done", {31'd0, stage_done_o}, 0);
    repeat (4) tick();
    @(negedge clk_i);
    check("rst_mid_busy_later", {31'd0, busy_o}, 0);
    tick();
    // feat_acc 0 vs thr 0 -> rval -1 < 0 -> fail; a leaked -100 would pick lval.
    send_thr(2'd0, 0);
    send_thr(2'd1, 1);
    send_thr(2'd2, 32'hFFFFFFFF);
    send_stage(0, 1'b0);
    wait_drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
